// File: rtl/aer_spike_encoder.sv
// Serialises parallel single-cycle spike strobes into {channel, timestamp} address-events.
// Per-channel pending latches hold one spike each and feed a round-robin arbiter that loads a one-entry output register.
module aer_spike_encoder #(
    parameter int NUM_CH   = 16,
    parameter int TS_W     = 20,
    parameter int TICK_DIV = 1,
    parameter int DROP_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    spike_in,
    input  logic                 aer_ready,
    output logic [TS_W+3:0]      aer_out,
    output logic                 aer_valid,
    output logic [TS_W-1:0]      ts_now,
    output logic [DROP_W-1:0]    drop_count
);

    localparam int CH_W  = 4;
    localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W = $clog2(NUM_CH + 1);
    localparam int SUM_W = DROP_W + CNT_W;
    localparam logic [PS_W-1:0]   PS_MAX   = PS_W'(TICK_DIV - 1);
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t               state_q;
    logic                 aer_valid_q;
    logic [TS_W+3:0]      aer_out_q;
    logic [CH_W-1:0]      rr_q;

    logic [PS_W-1:0]      presc_q, presc_d;
    logic [TS_W-1:0]      ts_q, ts_d;
    logic                 tick;

    logic [NUM_CH-1:0]    pend_q, pend_d;
    logic [TS_W-1:0]      ts_cap_q [NUM_CH];

    logic [DROP_W-1:0]    drop_q, drop_d;
    logic [CNT_W-1:0]     drop_n;
    logic [SUM_W-1:0]     drop_sum;

    logic                 gnt_found;
    logic [CH_W-1:0]      gnt_idx;
    logic                 do_grant;
    logic [NUM_CH-1:0]    gnt_oh;
    logic [NUM_CH-1:0]    cap_vec;
    logic [NUM_CH-1:0]    drop_vec;

    // Timestamp base: prescaler wraps at TICK_DIV-1, ts advances on that cycle.
    assign tick    = (presc_q == PS_MAX);
    assign presc_d = tick ? '0 : presc_q + 1'b1;
    assign ts_d    = tick ? ts_q + 1'b1 : ts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            ts_q    <= '0;
        end else begin
            presc_q <= presc_d;
            ts_q    <= ts_d;
        end
    end

    // First pending channel at or above rr_q, wrapping modulo 16.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!gnt_found && pend_q[rr_q + CH_W'(k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = rr_q + CH_W'(k);
            end
        end
    end

    assign do_grant = gnt_found && ((state_q == S_EMPTY) || aer_ready);
    assign gnt_oh   = do_grant ? (NUM_CH'(1) << gnt_idx) : '0;

    // A channel being granted this edge frees its latch, so a coincident spike is kept, not dropped.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign cap_vec[gi]  = spike_in[gi] & (~pend_q[gi] | gnt_oh[gi]);
        assign drop_vec[gi] = spike_in[gi] & pend_q[gi] & ~gnt_oh[gi];
    end

    assign pend_d = (pend_q & ~gnt_oh) | cap_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                ts_cap_q[i] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            for (int i = 0; i < NUM_CH; i++) begin
                if (cap_vec[i]) begin
                    ts_cap_q[i] <= ts_q;
                end
            end
        end
    end

    always_comb begin
        drop_n = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            drop_n = drop_n + CNT_W'(drop_vec[i]);
        end
    end

    assign drop_sum = SUM_W'(drop_q) + SUM_W'(drop_n);
    assign drop_d   = (drop_sum > SUM_W'(DROP_MAX)) ? DROP_MAX : drop_sum[DROP_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    // Output register: a held word stays untouched until the downstream takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            aer_valid_q <= 1'b0;
            aer_out_q   <= '0;
            rr_q        <= '0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (do_grant) begin
                        aer_out_q   <= {gnt_idx, ts_cap_q[gnt_idx]};
                        rr_q        <= gnt_idx + 1'b1;
                        aer_valid_q <= 1'b1;
                        state_q     <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (aer_ready) begin
                        if (do_grant) begin
                            aer_out_q <= {gnt_idx, ts_cap_q[gnt_idx]};
                            rr_q      <= gnt_idx + 1'b1;
                        end else begin
                            aer_valid_q <= 1'b0;
                            state_q     <= S_EMPTY;
                        end
                    end
                end
            endcase
        end
    end

    assign aer_out    = aer_out_q;
    assign aer_valid  = aer_valid_q;
    assign ts_now     = ts_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_aer_spike_encoder.sv
// Bench for aer_spike_encoder: event-level reference model compared every cycle, plus hand-computed event checks.
module tb_aer_spike_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] spike_in = '0;
    logic        aer_ready = 1'b1;
    logic [23:0] aer_out;
    logic        aer_valid;
    logic [19:0] ts_now;
    logic [7:0]  drop_count;

    logic [15:0] spike2 = '0;
    logic [11:0] aer_out2;
    logic        aer_valid2;
    logic [7:0]  ts_now2;
    logic [7:0]  drop2;

    aer_spike_encoder dut (
        .clk(clk), .rst_n(rst_n), .spike_in(spike_in), .aer_ready(aer_ready),
        .aer_out(aer_out), .aer_valid(aer_valid), .ts_now(ts_now), .drop_count(drop_count)
    );

    aer_spike_encoder #(.TS_W(8), .TICK_DIV(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .spike_in(spike2), .aer_ready(1'b1),
        .aer_out(aer_out2), .aer_valid(aer_valid2), .ts_now(ts_now2), .drop_count(drop2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] w(input int ch, input int ts);
        return {ch[3:0], ts[19:0]};
    endfunction

    // Reference model: spike bookkeeping per channel, one output slot.
    int          edges;
    bit          m_pend [16];
    int          m_tsc  [16];
    int          m_rr;
    bit          m_valid;
    logic [23:0] m_word;
    int          m_drop;
    int          g, nd, ts_b;
    logic [23:0] nxt_word;

    initial begin
        forever begin
            if (!rst_n) begin
                edges = 0; m_rr = 0; m_valid = 0; m_word = '0; m_drop = 0;
                for (int i = 0; i < 16; i++) begin m_pend[i] = 0; m_tsc[i] = 0; end
            end else begin
                ts_b = edges % (1 << 20);
                g = -1;
                nd = 0;
                nxt_word = '0;
                if (!m_valid || aer_ready)
                    for (int k = 0; k < 16; k++)
                        if (g < 0 && m_pend[(m_rr + k) % 16]) g = (m_rr + k) % 16;
                if (g >= 0) nxt_word = w(g, m_tsc[g]);
                for (int i = 0; i < 16; i++) begin
                    if (spike_in[i]) begin
                        if (!m_pend[i] || i == g) begin m_pend[i] = 1; m_tsc[i] = ts_b; end
                        else nd++;
                    end else if (i == g) m_pend[i] = 0;
                end
                if (g >= 0) begin m_valid = 1; m_word = nxt_word; m_rr = (g + 1) % 16; end
                else if (m_valid && aer_ready) m_valid = 0;
                m_drop = (m_drop + nd > 255) ? 255 : m_drop + nd;
                edges++;
            end
            @(posedge clk or negedge rst_n);
        end
    end

    // Per-cycle comparison and log of words the downstream actually accepts.
    logic [23:0] dut_log [$];
    initial begin
        forever begin
            @(negedge clk);
            chk("valid", aer_valid, m_valid);
            if (m_valid) chk("aer_out", aer_out, m_word);
            chk("ts_now", ts_now, edges % (1 << 20));
            chk("drop", drop_count, m_drop);
            chk("ts_now2", ts_now2, (edges / 4) % 256);
            if (aer_valid && aer_ready && rst_n) dut_log.push_back(aer_out);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic pulse(input logic [15:0] m, output int ts);
        spike_in = m;
        ts = edges;
        @(posedge clk); #2;
        spike_in = '0;
    endtask

    task automatic wait_edges(input int target);
        int n;
        n = 0;
        while (edges != target && n < 5000) begin @(posedge clk); #2; n++; end
        chk("wait_edges", edges, target);
    endtask

    int tsA, tsB, tsC, tsD, tsE, tsF, tsG, tsx, base;
    logic [11:0] ev2;
    bit seen2;

    initial begin
        idle(3);
        chk("rst_valid", aer_valid, 0);
        chk("rst_out", aer_out, 0);
        chk("rst_ts", ts_now, 0);
        chk("rst_drop", drop_count, 0);
        rst_n = 1'b1;

        // Single spike on ch10 at ts 0x345, ready high.
        wait_edges('h345);
        pulse(16'h0400, tsA);
        idle(4);
        chk("t1_n", dut_log.size(), 1);
        chk("t1_ev", dut_log[0], 24'hA00345);
        chk("t1_drop", drop_count, 0);

        // Simultaneous ch3+ch10, then ch2, then ch1+ch4 (rr now 3).
        pulse(16'h0408, tsA);
        idle(4);
        chk("t2_ev0", dut_log[1], w(3, tsA));
        chk("t2_ev1", dut_log[2], w(10, tsA));
        pulse(16'h0004, tsB);
        idle(4);
        chk("t2_ev2", dut_log[3], w(2, tsB));
        pulse(16'h0012, tsC);
        idle(4);
        chk("t2_ev3", dut_log[4], w(4, tsC));
        chk("t2_ev4", dut_log[5], w(1, tsC));

        // Backpressure: held word stable, second ch5 spike dropped.
        aer_ready = 1'b0;
        pulse(16'h0080, tsD);
        idle(3);
        pulse(16'h0020, tsE);
        idle(2);
        pulse(16'h0020, tsx);
        idle(3);
        chk("t3_drop", drop_count, 1);
        chk("t3_hold", aer_out, w(7, tsD));
        chk("t3_hold_v", aer_valid, 1);
        aer_ready = 1'b1;
        idle(4);
        chk("t3_n", dut_log.size(), 8);
        chk("t3_ev0", dut_log[6], w(7, tsD));
        chk("t3_ev1", dut_log[7], w(5, tsE));

        // Asynchronous reset with an event held and four pending.
        aer_ready = 1'b0;
        pulse(16'h0080, tsx);
        idle(2);
        pulse(16'h001E, tsx);
        idle(2);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("t5_valid", aer_valid, 0);
        chk("t5_out", aer_out, 0);
        chk("t5_ts", ts_now, 0);
        chk("t5_drop", drop_count, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        aer_ready = 1'b1;
        base = dut_log.size();
        idle(20);
        chk("t5_stale", dut_log.size(), base);

        // Prescaled timestamp (TICK_DIV=4, 8-bit) wrapping, spike just after wrap.
        wait_edges(1023);
        chk("t4_ff", ts_now2, 8'hFF);
        idle(1);
        chk("t4_wrap", ts_now2, 8'h00);
        spike2 = 16'h0200;
        @(posedge clk); #2;
        spike2 = '0;
        seen2 = 0;
        ev2 = '0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            if (aer_valid2 && !seen2) begin seen2 = 1; ev2 = aer_out2; end
        end
        chk("t4_seen", seen2, 1);
        chk("t4_ev", ev2, 12'h900);
        chk("t4_drop", drop2, 0);

        // Drop counting and saturation under backpressure, then drain in order.
        aer_ready = 1'b0;
        pulse(16'h8000, tsF);
        idle(3);
        pulse(16'hFFFF, tsG);
        pulse(16'hFFFF, tsx);
        idle(1);
        chk("t6_drop16", drop_count, 16);
        repeat (15) pulse(16'hFFFF, tsx);
        idle(1);
        chk("t6_sat", drop_count, 255);
        pulse(16'hFFFF, tsx);
        idle(1);
        chk("t6_sat2", drop_count, 255);
        base = dut_log.size();
        aer_ready = 1'b1;
        idle(25);
        chk("t6_n", dut_log.size() - base, 17);
        chk("t6_held", dut_log[base], w(15, tsF));
        for (int i = 0; i < 16; i++) chk("t6_order", dut_log[base + 1 + i], w(i, tsG));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
